cfu_ram_responder: RTL and testbench

Wishbone B4 responder (slave) that terminates the CFU RAM bus driven by the CFU's Wishbone RAM controller, backing it with an internal word-addressed SRAM. It serves single classic reads and writes with byte selects and incrementing bursts (CTI/BTE). Programmable wait states exercise the initiator's pending states. It signals `err` for out-of-window addresses. It serves as the bench/FPGA-side memory model and as a CFU-local scratchpad.

---
 rtl/cfu_ram_responder.sv | 182 ++++++++++++++++++
 tb/tb_cfu_ram_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_ram_responder.sv
// Wishbone B4 responder backed by a word-addressed SRAM.
// Classic and incrementing bursts, wait states, out-of-window errors.
module cfu_ram_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [29:0] BASE_ADR    = 30'h0,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] cfu_ram_adr,
    input  logic [31:0] cfu_ram_dat_mosi,
    input  logic [3:0]  cfu_ram_sel,
    input  logic        cfu_ram_cyc,
    input  logic        cfu_ram_stb,
    input  logic        cfu_ram_we,
    input  logic [2:0]  cfu_ram_cti,
    input  logic [1:0]  cfu_ram_bte,
    output logic [31:0] cfu_ram_dat_miso,
    output logic        cfu_ram_ack,
    output logic        cfu_ram_err,
    output logic        burst_active
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_BURST} state_t;

    state_t      state;
    logic        rst_q;
    logic [3:0]  wcnt;
    logic [29:0] lat_adr;
    logic [31:0] lat_dat;
    logic [3:0]  lat_sel;
    logic        lat_we;
    logic [2:0]  lat_cti;
    logic [1:0]  lat_bte;
    logic [29:0] bcnt;
    logic        fin;

    logic [31:0] mem [DEPTH];

    logic [29:0]   first_idx;
    logic [29:0]   burst_idx;
    logic          first_ok;
    logic          burst_ok;
    logic          cont;
    logic          beat;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_dat;
    logic [3:0]    wr_sel;

    // Next burst address: linear, or wrap within a 4/8/16-word block.
    function automatic logic [29:0] next_adr(input logic [29:0] a,
                                             input logic [1:0]  bte);
        logic [29:0] m;
        case (bte)
            2'b01:   m = 30'h3;
            2'b10:   m = 30'h7;
            2'b11:   m = 30'hF;
            default: m = 30'h0;
        endcase
        if (m == 30'h0) next_adr = a + 30'd1;
        else            next_adr = (a & ~m) | ((a + 30'd1) & m);
    endfunction

    // Assert asynchronously, release on the following clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_q <= 1'b0;
        else        rst_q <= 1'b1;
    end

    // Window decode, burst-beat qualification and write-port selection.
    always_comb begin
        first_idx = lat_adr - BASE_ADR;
        burst_idx = bcnt - BASE_ADR;
        first_ok  = first_idx < DEPTH_W;
        burst_ok  = burst_idx < DEPTH_W;
        cont      = (state == S_RESP) && cfu_ram_ack &&
                    (lat_cti == 3'b010) && cfu_ram_cyc;
        beat      = (cont || (state == S_BURST && !fin)) &&
                    cfu_ram_cyc && cfu_ram_stb;
        wr_en     = 1'b0;
        wr_idx    = first_idx[AW-1:0];
        wr_dat    = lat_dat;
        wr_sel    = lat_sel;
        if (state == S_WAIT && wcnt == 4'd0 && cfu_ram_cyc &&
            lat_we && first_ok) begin
            wr_en = 1'b1;
        end else if (beat && cfu_ram_we && burst_ok) begin
            wr_en  = 1'b1;
            wr_idx = burst_idx[AW-1:0];
            wr_dat = cfu_ram_dat_mosi;
            wr_sel = cfu_ram_sel;
        end
    end

    // Byte-masked SRAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_sel[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

    // Bus FSM with registered ack/err/read data.
    always_ff @(posedge clk or negedge rst_q) begin
        if (!rst_q) begin
            state            <= S_IDLE;
            wcnt             <= 4'd0;
            lat_adr          <= 30'd0;
            lat_dat          <= 32'd0;
            lat_sel          <= 4'd0;
            lat_we           <= 1'b0;
            lat_cti          <= 3'd0;
            lat_bte          <= 2'd0;
            bcnt             <= 30'd0;
            fin              <= 1'b0;
            cfu_ram_ack      <= 1'b0;
            cfu_ram_err      <= 1'b0;
            cfu_ram_dat_miso <= 32'd0;
        end else begin
            cfu_ram_ack      <= 1'b0;
            cfu_ram_err      <= 1'b0;
            cfu_ram_dat_miso <= 32'd0;
            case (state)
                S_IDLE: begin
                    fin <= 1'b0;
                    if (cfu_ram_cyc && cfu_ram_stb &&
                        !cfu_ram_ack && !cfu_ram_err) begin
                        lat_adr <= cfu_ram_adr;
                        lat_dat <= cfu_ram_dat_mosi;
                        lat_sel <= cfu_ram_sel;
                        lat_we  <= cfu_ram_we;
                        lat_cti <= cfu_ram_cti;
                        lat_bte <= cfu_ram_bte;
                        wcnt    <= 4'(WAIT_CYCLES);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!cfu_ram_cyc) begin
                        state <= S_IDLE;
                    end else if (wcnt == 4'd0) begin
                        state       <= S_RESP;
                        cfu_ram_ack <= first_ok;
                        cfu_ram_err <= !first_ok;
                        bcnt        <= next_adr(lat_adr, lat_bte);
                        if (first_ok && !lat_we)
                            cfu_ram_dat_miso <= mem[first_idx[AW-1:0]];
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                default: begin
                    if (!cfu_ram_cyc || fin ||
                        (state == S_RESP && !cont)) begin
                        state <= S_IDLE;
                        fin   <= 1'b0;
                    end else begin
                        state <= S_BURST;
                        if (beat) begin
                            cfu_ram_ack <= burst_ok;
                            cfu_ram_err <= !burst_ok;
                            if (burst_ok && !cfu_ram_we)
                                cfu_ram_dat_miso <= mem[burst_idx[AW-1:0]];
                            if (burst_ok)
                                bcnt <= next_adr(bcnt, lat_bte);
                            if (!burst_ok || cfu_ram_cti == 3'b111)
                                fin <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign burst_active = (state == S_BURST);

endmodule

// File: tb/tb_cfu_ram_responder.sv
// Scoreboard bench for cfu_ram_responder: singles, byte selects,
// linear/wrap bursts, window errors, abort and async reset.
module tb_cfu_ram_responder;

    localparam int DEPTH = 64;
    localparam int WC    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] adr = '0;
    logic [31:0] dat_mosi = '0;
    logic [3:0]  sel = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] dat_miso;
    logic        ack;
    logic        err;
    logic        bact;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic        e;
        logic        rd;
        logic [31:0] d;
    } exp_t;
    exp_t q[$];

    cfu_ram_responder #(
        .DEPTH(DEPTH),
        .BASE_ADR(30'h0),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfu_ram_adr(adr),
        .cfu_ram_dat_mosi(dat_mosi),
        .cfu_ram_sel(sel),
        .cfu_ram_cyc(cyc),
        .cfu_ram_stb(stb),
        .cfu_ram_we(we),
        .cfu_ram_cti(cti),
        .cfu_ram_bte(bte),
        .cfu_ram_dat_miso(dat_miso),
        .cfu_ram_ack(ack),
        .cfu_ram_err(err),
        .burst_active(bact)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Model a beat: update reference memory for writes, queue expectation.
    task automatic push_beat(input logic [29:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s);
        exp_t x;
        x.e  = !(a < 30'(DEPTH));
        x.rd = !w;
        x.d  = '0;
        if (!x.e) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
            end else begin
                x.d = mdl[a];
            end
        end
        q.push_back(x);
    endtask

    task automatic check_beat(input string tag);
        exp_t x;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end
        if (q.size() > 0) begin
            x = q.pop_front();
            chk({tag, "_ack"}, 32'(ack), 32'(!x.e));
            chk({tag, "_err"}, 32'(err), 32'(x.e));
            if (x.rd && !x.e) chk({tag, "_dat"}, dat_miso, x.d);
        end
    endtask

    task automatic wait_resp(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack || err) && n < 20);
        chk({tag, "_resp"}, 32'(ack || err), 32'd1);
    endtask

    task automatic single(input logic [29:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s,
                          input string tag);
        int n;
        push_beat(a, w, d, s);
        adr = a; we = w; dat_mosi = d; sel = s;
        cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        wait_resp(tag, n);
        chk({tag, "_lat"}, 32'(n), 32'(WC + 2));
        check_beat(tag);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, "_drop"}, 32'(ack || err), 32'd0);
    endtask

    function automatic logic [29:0] baddr(input logic [29:0] s,
                                          input logic [1:0] b,
                                          input int i);
        int nn;
        if (b == 2'b00) return s + 30'(i);
        nn = 2 << b;
        return (s - (s % 30'(nn))) + ((s % 30'(nn)) + 30'(i)) % 30'(nn);
    endfunction

    task automatic burst(input logic [29:0] s, input logic [1:0] b,
                         input int len, input logic w, input string tag);
        int n;
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  sl;
        logic        was_err;
        d  = $urandom;
        sl = w ? 4'($urandom_range(1, 15)) : 4'hF;
        push_beat(s, w, d, sl);
        adr = s; we = w; dat_mosi = d; sel = sl; bte = b;
        cti = (len == 1) ? 3'b111 : 3'b010;
        cyc = 1'b1; stb = 1'b1;
        wait_resp(tag, n);
        chk({tag, "_lat"}, 32'(n), 32'(WC + 2));
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                @(negedge clk);
                chk({tag, "_consec"}, 32'(ack || err), 32'd1);
                chk({tag, "_bact"}, 32'(bact), 32'd1);
            end
            was_err = err;
            check_beat(tag);
            if (was_err || i == len - 1) break;
            a  = baddr(s, b, i + 1);
            d  = $urandom;
            sl = w ? 4'($urandom_range(1, 15)) : 4'hF;
            push_beat(a, w, d, sl);
            adr = ~a; dat_mosi = d; sel = sl;
            cti = (i + 1 == len - 1) ? 3'b111 : 3'b010;
        end
        q.delete();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(negedge clk);
        chk({tag, "_end_ack"}, 32'(ack || err), 32'd0);
        chk({tag, "_end_bact"}, 32'(bact), 32'd0);
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #1;
        chk("rst_async_ack", 32'(ack), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dat", dat_miso, 32'd0);
        chk("rst_bact", 32'(bact), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < DEPTH; i++)
            single(30'(i), 1'b1, $urandom, 4'hF, "pre");

        single(30'd5, 1'b1, 32'hDEADBEEF, 4'hF, "wr5");
        single(30'd5, 1'b0, 32'h0, 4'hF, "rd5");
        single(30'd7, 1'b1, 32'h11223344, 4'hF, "wr7");
        single(30'd7, 1'b1, 32'hAABBCCDD, 4'b0101, "sel7");
        single(30'd7, 1'b0, 32'h0, 4'hF, "rd7");

        burst(30'd8, 2'b00, 4, 1'b0, "lin4");
        burst(30'h0E, 2'b01, 4, 1'b0, "wrap4");
        burst(30'd19, 2'b10, 8, 1'b1, "wwrap8");
        burst(30'd16, 2'b00, 8, 1'b0, "rd8");
        burst(30'd40, 2'b11, 3, 1'b0, "wrap16");

        single(30'(DEPTH), 1'b1, 32'hCAFEF00D, 4'hF, "oor_wr");
        single(30'd0, 1'b0, 32'h0, 4'hF, "oor_chk");
        burst(30'd62, 2'b00, 4, 1'b0, "cross");

        adr = 30'd20; we = 1'b1; dat_mosi = 32'h5555AAAA; sel = 4'hF;
        cti = 3'b000; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_resp", 32'(ack || err), 32'd0);
        end
        single(30'd20, 1'b0, 32'h0, 4'hF, "abort_rd");

        adr = 30'd0; we = 1'b0; sel = 4'hF; bte = 2'b00;
        cti = 3'b010; cyc = 1'b1; stb = 1'b1;
        wait_resp("mid", n);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("mid_pre_ack", 32'(ack), 32'd1);
        chk("mid_pre_bact", 32'(bact), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_bact", 32'(bact), 32'd0);
        chk("mid_rst_dat", dat_miso, 32'd0);
        q.delete();
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        single(30'd3, 1'b0, 32'h0, 4'hF, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
